// File: rtl/xorshift32_checker_if.sv
// Received word stream feeding xorshift32_checker: the source drives it through
// the master modport, and the checker samples it through the slave modport.
interface xorshift32_checker_if;
  logic        in_valid;
  logic [31:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/xorshift32_checker.sv
// Sink-side xorshift32 stream checker: self-synchronises on the stream, then counts mismatching words.
// Define XORSHIFT32_CHK_BITERR_EN to add the saturating bit_err_count output (popcount of each error).
module xorshift32_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  xorshift32_checker_if.slave  rx,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_count
`ifdef XORSHIFT32_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0]     bit_err_count
`endif
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pred_reg, pred_next;
  logic [MATCH_W-1:0] match_reg, match_next, match_inc;
  logic [MISS_W-1:0]  miss_reg, miss_next, miss_inc;
  logic [CNT_W-1:0]   err_count_reg, err_count_next;
  logic               err_pulse_reg, err_pulse_next;
  logic [31:0]        pred_step, seed_step;
  logic               hit, data_zero;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign pred_step = xs_next(pred_reg);
  assign seed_step = xs_next(rx.in_data);
  assign hit       = (rx.in_data == pred_reg);
  assign data_zero = (rx.in_data == 32'h0);
  assign match_inc = match_reg + 1'b1;
  assign miss_inc  = miss_reg + 1'b1;

`ifdef XORSHIFT32_CHK_BITERR_EN
  logic [CNT_W-1:0] bit_err_reg, bit_err_next, bit_err_sat;
  logic [5:0]       err_bits;
  logic [CNT_W+6:0] bit_err_sum;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  assign err_bits    = popcount32(rx.in_data ^ pred_reg);
  assign bit_err_sum = (CNT_W+7)'(bit_err_reg) + (CNT_W+7)'(err_bits);
  assign bit_err_sat = (bit_err_sum > (CNT_W+7)'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                                   : bit_err_sum[CNT_W-1:0];
  assign bit_err_count = bit_err_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= HUNT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = HUNT;
    end else if (rx.in_valid) begin
      case (state_reg)
        HUNT:    if (!data_zero) state_next = VERIFY;
        VERIFY: begin
          if (hit) begin
            if (match_inc == MATCH_W'(LOCK_CNT)) state_next = LOCKED;
          end else if (data_zero) begin
            state_next = HUNT;
          end
        end
        LOCKED:  if (!hit && (miss_inc == MISS_W'(UNLOCK_CNT))) state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  // Once locked the predictor free-runs, so a corrupted word never reseeds it.
  always_comb begin
    pred_next      = pred_reg;
    match_next     = match_reg;
    miss_next      = miss_reg;
    err_count_next = err_count_reg;
    err_pulse_next = 1'b0;
`ifdef XORSHIFT32_CHK_BITERR_EN
    bit_err_next   = bit_err_reg;
`endif
    if (clear) begin
      pred_next      = '0;
      match_next     = '0;
      miss_next      = '0;
      err_count_next = '0;
`ifdef XORSHIFT32_CHK_BITERR_EN
      bit_err_next   = '0;
`endif
    end else if (rx.in_valid) begin
      case (state_reg)
        HUNT: begin
          if (!data_zero) begin
            pred_next  = seed_step;
            match_next = '0;
          end
        end
        VERIFY: begin
          miss_next = '0;
          if (hit) begin
            pred_next  = pred_step;
            match_next = (state_next == LOCKED) ? '0 : match_inc;
          end else begin
            pred_next  = data_zero ? 32'h0 : seed_step;
            match_next = '0;
          end
        end
        LOCKED: begin
          pred_next = (state_next == HUNT) ? 32'h0 : pred_step;
          if (hit) begin
            miss_next = '0;
          end else begin
            err_pulse_next = 1'b1;
            err_count_next = (&err_count_reg) ? err_count_reg : err_count_reg + 1'b1;
            miss_next      = (state_next == HUNT) ? '0 : miss_inc;
`ifdef XORSHIFT32_CHK_BITERR_EN
            bit_err_next   = bit_err_sat;
`endif
          end
        end
        default: pred_next = '0;
      endcase
    end
  end

  assign locked    = (state_reg == LOCKED);
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_reg      <= '0;
      match_reg     <= '0;
      miss_reg      <= '0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
`ifdef XORSHIFT32_CHK_BITERR_EN
      bit_err_reg   <= '0;
`endif
    end else begin
      pred_reg      <= pred_next;
      match_reg     <= match_next;
      miss_reg      <= miss_next;
      err_count_reg <= err_count_next;
      err_pulse_reg <= err_pulse_next;
`ifdef XORSHIFT32_CHK_BITERR_EN
      bit_err_reg   <= bit_err_next;
`endif
    end
  end

endmodule

// File: tb/tb_xorshift32_checker.sv
// Scoreboard bench for xorshift32_checker: dut_a uses default parameters, dut_b is the
// CNT_W=4 / UNLOCK_CNT=32 saturation instance.
module tb_xorshift32_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clear_a, clear_b;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
`ifdef XORSHIFT32_CHK_BITERR_EN
  logic [15:0] bec_a;
  logic [3:0]  bec_b;
`endif

  xorshift32_checker_if bus_a ();
  xorshift32_checker_if bus_b ();

  xorshift32_checker dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a), .rx(bus_a),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a)
`ifdef XORSHIFT32_CHK_BITERR_EN
    , .bit_err_count(bec_a)
`endif
  );

  xorshift32_checker #(.LOCK_CNT(4), .UNLOCK_CNT(32), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b), .rx(bus_b),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b)
`ifdef XORSHIFT32_CHK_BITERR_EN
    , .bit_err_count(bec_b)
`endif
  );

  typedef struct {
    bit          sel;
    logic        locked;
    logic        pulse;
    logic [31:0] cnt;
    logic [31:0] bec;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          mon_n;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ebec_a   = 0;
  int          ebec_b   = 0;
  logic [31:0] x;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One word (or idle cycle) per call; its expected outcome is queued for the monitor.
  task automatic step(input bit sel, input logic v, input logic [31:0] d, input logic clr,
                      input logic el, input logic ep, input int ec, input string tag);
    exp_t e;
    if (!sel) begin
      bus_a.in_valid = v; bus_a.in_data = d; clear_a = clr;
    end else begin
      bus_b.in_valid = v; bus_b.in_data = d; clear_b = clr;
    end
    e.sel = sel; e.locked = el; e.pulse = ep; e.cnt = ec;
    e.bec = sel ? ebec_b : ebec_a; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      mon_n = sb_q.size();
      #1;
      if (mon_n > 0) begin
        mon_e = sb_q.pop_front();
        if (!mon_e.sel) begin
          $display("txn %s dut_a locked=%0b pulse=%0b err_count=%0d", mon_e.tag, locked_a, pulse_a, cnt_a);
          check_eq({mon_e.tag, "_locked"}, 32'(locked_a), 32'(mon_e.locked));
          check_eq({mon_e.tag, "_pulse"},  32'(pulse_a),  32'(mon_e.pulse));
          check_eq({mon_e.tag, "_count"},  32'(cnt_a),    mon_e.cnt);
`ifdef XORSHIFT32_CHK_BITERR_EN
          check_eq({mon_e.tag, "_biterr"}, 32'(bec_a),    mon_e.bec);
`endif
        end else begin
          $display("txn %s dut_b locked=%0b pulse=%0b err_count=%0d", mon_e.tag, locked_b, pulse_b, cnt_b);
          check_eq({mon_e.tag, "_locked"}, 32'(locked_b), 32'(mon_e.locked));
          check_eq({mon_e.tag, "_pulse"},  32'(pulse_b),  32'(mon_e.pulse));
          check_eq({mon_e.tag, "_count"},  32'(cnt_b),    mon_e.cnt);
`ifdef XORSHIFT32_CHK_BITERR_EN
          check_eq({mon_e.tag, "_biterr"}, 32'(bec_b),    mon_e.bec);
`endif
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    #1;
    check_eq("rst_locked", 32'(locked_a), 32'd0);
    check_eq("rst_pulse",  32'(pulse_a),  32'd0);
    check_eq("rst_count",  32'(cnt_a),    32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero words in HUNT are ignored.
    for (int i = 0; i < 4; i++) step(0, 1, 32'h0, 0, 0, 0, 0, "hunt_zero");

    // Lock: seed plus LOCK_CNT matches.
    x = 32'h12345678;
    step(0, 1, x, 0, 0, 0, 0, "t1_seed");
    for (int i = 1; i <= 4; i++) begin
      x = xs(x);
      step(0, 1, x, 0, (i == 4), 0, 0, "t1_lock");
    end
    for (int i = 0; i < 3; i++) begin
      x = xs(x);
      step(0, 1, x, 0, 1, 0, 0, "t1_run");
    end

    // Single-bit error, then a clean word still matches.
    x = xs(x); ebec_a += 1;
    step(0, 1, x ^ 32'h1, 0, 1, 1, 1, "t2_err");
    x = xs(x);
    step(0, 1, x, 0, 1, 0, 1, "t2_clean");

    // Idle cycles with garbage data hold everything.
    for (int i = 0; i < 10; i++) step(0, 0, 32'hFFFFFFFF, 0, 1, 0, 1, "t4_idle");
    for (int i = 0; i < 2; i++) begin
      x = xs(x);
      step(0, 1, x, 0, 1, 0, 1, "t4_resume");
    end

    // Three consecutive bad words drop lock; the third still counts.
    for (int i = 0; i < 3; i++) begin
      x = xs(x); ebec_a += 32 - $countones(x);
      step(0, 1, 32'hFFFFFFFF, 0, (i < 2), 1, 2 + i, "t3_unlock");
    end
    for (int i = 0; i < 5; i++) begin
      x = xs(x);
      step(0, 1, x, 0, (i == 4), 0, 4, "t3_relock");
    end

    // Clear beats a valid word in the same cycle.
    ebec_a = 0; x = xs(x);
    step(0, 1, x, 1, 0, 0, 0, "clear_a");

    // VERIFY mismatch reseeds from the received word.
    step(0, 1, 32'h12345678, 0, 0, 0, 0, "t5_seed");
    x = 32'hDEADBEEF;
    step(0, 1, x, 0, 0, 0, 0, "t5_reseed");
    for (int i = 1; i <= 4; i++) begin
      x = xs(x);
      step(0, 1, x, 0, (i == 4), 0, 0, "t5_lock");
    end

    // A zero word in VERIFY returns to HUNT, so further zeros never lock.
    step(0, 0, 32'h0, 1, 0, 0, 0, "clear_idle");
    step(0, 1, 32'h12345678, 0, 0, 0, 0, "vz_seed");
    for (int i = 0; i < 5; i++) step(0, 1, 32'h0, 0, 0, 0, 0, "vz_zero");

    // Lock, take one error, then reset mid-stream.
    x = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, x, 0, (i == 4), 0, 0, "rs_lock");
      x = xs(x);
    end
    ebec_a += 4;
    step(0, 1, x ^ 32'h000000F0, 0, 1, 1, 1, "rs_err");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_locked", 32'(locked_a), 32'd0);
    check_eq("midrst_count",  32'(cnt_a),    32'd0);
    ebec_a = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = xs(x);
      step(0, 1, x, 0, (i == 4), 0, 0, "rs_relock");
    end

    // Saturation on the narrow instance, then clear with a valid word.
    x = 32'h0BADC0DE;
    step(1, 1, x, 0, 0, 0, 0, "t6_seed");
    for (int i = 1; i <= 4; i++) begin
      x = xs(x);
      step(1, 1, x, 0, (i == 4), 0, 0, "t6_lock");
    end
    for (int i = 1; i <= 20; i++) begin
      x = xs(x);
      ebec_b = (ebec_b + 32 - $countones(x) > 15) ? 15 : ebec_b + 32 - $countones(x);
      step(1, 1, 32'hFFFFFFFF, 0, 1, 1, (i > 15) ? 15 : i, "t6_sat");
    end
    ebec_b = 0; x = xs(x);
    step(1, 1, x, 1, 0, 0, 0, "t6_clear");

    @(posedge clk);
    #3;
    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
